// File: rtl/load_unit.sv
// Load-side data-memory port: issues one word-aligned read per MIPS load,
// waits for a variable-latency ack, then extracts and extends the addressed lane.
module load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [5:0]  ld_op,
    input  logic [31:0] ld_addr,
    input  logic [4:0]  ld_rt,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rt,
    output logic        wb_err_align,
    output logic        wb_err_bus,
    output logic [1:0]  dbg_state
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    localparam int unsigned     CW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              HAS_TIMEOUT = (TIMEOUT != 0);
    localparam logic [CW-1:0]   CNT_LAST    = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [5:0]    op_q;
    logic [1:0]    lane_q;
    logic [4:0]    rt_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          in_is_load;
    logic          in_misaligned;
    logic          timeout_hit;

    logic          res_load;
    logic [31:0]   res_data;
    logic [4:0]    res_rt;
    logic          res_align;
    logic          res_bus;

    // Handshake: a request transfers on a rising edge where ld_valid && ld_ready;
    // ld_ready is high only in IDLE, so one load is in flight at a time.
    assign accept    = ld_valid && ld_ready;
    assign ld_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_WAIT);
    assign wb_valid  = (state_q == S_DONE);
    assign dbg_state = state_q;

    assign timeout_hit = HAS_TIMEOUT && (cnt_q == CNT_LAST);

    function automatic logic [31:0] extract(input logic [5:0]  op,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Classify the incoming request; non-load opcodes are accepted and dropped.
    always_comb begin
        in_is_load    = 1'b0;
        in_misaligned = 1'b0;
        case (ld_op)
            OP_LB, OP_LBU: in_is_load = 1'b1;
            OP_LH, OP_LHU: begin
                in_is_load    = 1'b1;
                in_misaligned = ld_addr[0];
            end
            OP_LW: begin
                in_is_load    = 1'b1;
                in_misaligned = |ld_addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        res_load  = 1'b0;
        res_data  = 32'h0;
        res_rt    = rt_q;
        res_align = 1'b0;
        res_bus   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && in_is_load) begin
                    if (in_misaligned) begin
                        state_d   = S_DONE;
                        res_load  = 1'b1;
                        res_rt    = ld_rt;
                        res_align = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d  = S_DONE;
                    res_load = 1'b1;
                    res_data = extract(op_q, lane_q, mem_rdata);
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    res_load = 1'b1;
                    res_bus  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 6'h0;
            lane_q       <= 2'h0;
            rt_q         <= 5'h0;
            cnt_q        <= '0;
            mem_addr     <= 32'h0;
            wb_data      <= 32'h0;
            wb_rt        <= 5'h0;
            wb_err_align <= 1'b0;
            wb_err_bus   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= ld_op;
                lane_q <= ld_addr[1:0];
                rt_q   <= ld_rt;
                cnt_q  <= '0;
                // mem_addr only moves when a real read is about to start
                if (in_is_load && !in_misaligned) begin
                    mem_addr <= {ld_addr[31:2], 2'b00};
                end
            end else if (state_q == S_WAIT && !mem_ack) begin
                cnt_q <= cnt_q + CW'(1);
            end
            // Result registers change only when a result is produced, so they
            // hold their last value whenever wb_valid is low.
            if (res_load) begin
                wb_data      <= res_data;
                wb_rt        <= res_rt;
                wb_err_align <= res_align;
                wb_err_bus   <= res_bus;
            end
        end
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        mem_req |-> (mem_addr[1:0] == 2'b00));

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_ack) |=> (!mem_req || $stable(mem_addr)));

    a_wb_pulse: assert property (@(posedge clk) disable iff (rst)
        wb_valid |=> !wb_valid);

    a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(ld_ready && (mem_req || wb_valid)));

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: lane extraction, latency, misalignment,
// timeout, late ack, reset abort and back-to-back streams.
module tb_load_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [5:0]  ld_op = 6'h0;
    logic [31:0] ld_addr = 32'h0;
    logic [4:0]  ld_rt = 5'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rt;
    logic        wb_err_align;
    logic        wb_err_bus;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    load_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_op        (ld_op),
        .ld_addr      (ld_addr),
        .ld_rt        (ld_rt),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rt        (wb_rt),
        .wb_err_align (wb_err_align),
        .wb_err_bus   (wb_err_bus),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to its wb_valid pulse.
    // ack_at: WAIT cycle (1 = first cycle after accept) carrying mem_ack; 0 = never.
    task automatic run_load(input string name, input logic [5:0] op, input logic [31:0] addr,
                            input logic [4:0] rt, input int ack_at, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input logic exp_align,
                            input logic exp_bus, input int exp_req);
        int          waited;
        int          req_cycles;
        bit          addr_ok;
        bit          ready_ok;
        bit          seen;
        logic [31:0] exp_word;
        waited = 0;
        while (!ld_ready && waited < 50) begin
            step();
            waited++;
        end
        check({name, ":ready"}, 32'(ld_ready), 32'd1);
        exp_q.push_back(exp_data);
        ld_valid = 1'b1;
        ld_op    = op;
        ld_addr  = addr;
        ld_rt    = rt;
        step();
        ld_valid = 1'b0;
        ld_op    = 6'h3F;
        ld_addr  = 32'hFFFF_FFFF;
        req_cycles = 0;
        addr_ok    = 1'b1;
        ready_ok   = 1'b1;
        seen       = 1'b0;
        for (int c = 1; c <= TIMEOUT + 8 && !seen; c++) begin
            if (ld_ready) ready_ok = 1'b0;
            if (wb_valid) begin
                seen = 1'b1;
                exp_word = exp_q.pop_front();
                check({name, ":wb_data"}, wb_data, exp_word);
                check({name, ":wb_rt"}, 32'(wb_rt), 32'(rt));
                check({name, ":err_align"}, 32'(wb_err_align), 32'(exp_align));
                check({name, ":err_bus"}, 32'(wb_err_bus), 32'(exp_bus));
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    if (mem_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
                end
                if (c == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                step();
                mem_ack   = 1'b0;
                mem_rdata = 32'h5A5A_5A5A;
            end
        end
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
        check({name, ":wb_seen"}, 32'(seen), 32'd1);
        check({name, ":req_cycles"}, 32'(req_cycles), 32'(exp_req));
        check({name, ":mem_addr"}, 32'(addr_ok), 32'd1);
        check({name, ":busy_ready"}, 32'(ready_ok), 32'd1);
        step();
        check({name, ":pulse"}, 32'(wb_valid), 32'd0);
        check({name, ":idle_ready"}, 32'(ld_ready), 32'd1);
        check({name, ":hold"}, wb_data, exp_data);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        check("rst:ld_ready", 32'(ld_ready), 32'd1);
        check("rst:mem_req", 32'(mem_req), 32'd0);
        check("rst:mem_addr", mem_addr, 32'h0);
        check("rst:wb_valid", 32'(wb_valid), 32'd0);
        check("rst:wb_data", wb_data, 32'h0);
        check("rst:wb_rt", 32'(wb_rt), 32'd0);
        check("rst:errs", {30'h0, wb_err_align, wb_err_bus}, 32'h0);
        rst = 1'b0;

        // Lane extraction with word 0x80FF1234, ack in the first WAIT cycle
        run_load("lb_103",  6'h20, 32'h0000_0103, 5'd3,  1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 1'b0, 1);
        run_load("lbu_103", 6'h24, 32'h0000_0103, 5'd4,  1, 32'h80FF_1234, 32'h0000_0080, 1'b0, 1'b0, 1);
        run_load("lhu_102", 6'h25, 32'h0000_0102, 5'd5,  1, 32'h80FF_1234, 32'h0000_80FF, 1'b0, 1'b0, 1);
        run_load("lh_100",  6'h21, 32'h0000_0100, 5'd6,  1, 32'h80FF_1234, 32'h0000_1234, 1'b0, 1'b0, 1);
        run_load("lh_102",  6'h21, 32'h0000_0102, 5'd8,  2, 32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 1'b0, 2);
        run_load("lb_101",  6'h20, 32'h0000_0101, 5'd9,  1, 32'h80FF_1234, 32'h0000_0012, 1'b0, 1'b0, 1);
        run_load("lb_102",  6'h20, 32'h0000_0102, 5'd10, 3, 32'h80FF_1234, 32'hFFFF_FFFF, 1'b0, 1'b0, 3);
        run_load("lbu_100", 6'h24, 32'h0000_0100, 5'd11, 1, 32'h80FF_1234, 32'h0000_0034, 1'b0, 1'b0, 1);

        // Word load with 5-cycle latency
        run_load("lw_200",  6'h23, 32'h0000_0200, 5'd17, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 5);

        // Misaligned: no memory access, result in the cycle after accept
        run_load("lw_202",  6'h23, 32'h0000_0202, 5'd18, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        run_load("lw_201",  6'h23, 32'h0000_0201, 5'd19, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        run_load("lh_101",  6'h21, 32'h0000_0101, 5'd20, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
        run_load("lhu_103", 6'h25, 32'h0000_0103, 5'd21, 0, 32'h0, 32'h0, 1'b1, 1'b0, 0);

        // Non-load opcode: accepted and dropped
        run_load("lbu_pre", 6'h24, 32'h0000_0010, 5'd2, 1, 32'h0000_7700, 32'h0000_0000, 1'b0, 1'b0, 1);
        run_load("lw_pre",  6'h23, 32'h0000_0010, 5'd2, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 1);
        ld_valid = 1'b1;
        ld_op    = 6'h2B;
        ld_addr  = 32'h0000_0400;
        ld_rt    = 5'd30;
        step();
        ld_valid = 1'b0;
        check("nonload:mem_req", 32'(mem_req), 32'd0);
        check("nonload:wb_valid", 32'(wb_valid), 32'd0);
        check("nonload:ld_ready", 32'(ld_ready), 32'd1);
        step();
        check("nonload:wb_valid2", 32'(wb_valid), 32'd0);
        check("nonload:hold", wb_data, 32'hCAFE_F00D);

        // Timeout with no ack, then a late ack that must be ignored
        run_load("lw_to", 6'h23, 32'h0000_0300, 5'd7, 0, 32'h0, 32'h0, 1'b0, 1'b1, TIMEOUT);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        check("late_ack:wb_valid", 32'(wb_valid), 32'd0);
        check("late_ack:mem_req", 32'(mem_req), 32'd0);
        check("late_ack:err_bus", 32'(wb_err_bus), 32'd1);
        check("late_ack:wb_data", wb_data, 32'h0);
        step();
        check("late_ack:wb_valid2", 32'(wb_valid), 32'd0);

        // Reset in the third WAIT cycle aborts the load
        ld_valid = 1'b1;
        ld_op    = 6'h23;
        ld_addr  = 32'h0000_0400;
        ld_rt    = 5'd12;
        step();
        ld_valid = 1'b0;
        check("abort:wait1", 32'(mem_req), 32'd1);
        step();
        step();
        check("abort:wait3", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort:mem_req", 32'(mem_req), 32'd0);
        check("abort:wb_valid", 32'(wb_valid), 32'd0);
        check("abort:ld_ready", 32'(ld_ready), 32'd1);
        check("abort:err_bus", 32'(wb_err_bus), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        check("abort:no_wb", 32'(wb_valid), 32'd0);
        check("abort:wb_data", wb_data, 32'h0);

        // Back-to-back stream
        run_load("s0_lb",  6'h20, 32'h0000_1000, 5'd1,  1, 32'h0000_00C3, 32'hFFFF_FFC3, 1'b0, 1'b0, 1);
        run_load("s1_lw",  6'h23, 32'h0000_1004, 5'd2,  2, 32'h0102_0304, 32'h0102_0304, 1'b0, 1'b0, 2);
        run_load("s2_lb",  6'h20, 32'h0000_1009, 5'd3,  1, 32'h0000_7F00, 32'h0000_007F, 1'b0, 1'b0, 1);
        run_load("s3_lhu", 6'h25, 32'h0000_100E, 5'd31, 4, 32'hFFFE_0000, 32'h0000_FFFE, 1'b0, 1'b0, 4);
        run_load("s4_lw",  6'h23, 32'hFFFF_FFFC, 5'd0,  1, 32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 1);

        check("exp_q:empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
